// File: rtl/if_sramlike_stage_pkg.sv
// Shared definitions for the sram-like instruction fetch stage:
// reset vector, redirect bundle widths, FS state encoding and buffer entry.
package if_sramlike_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int          DISC_W_DEFAULT   = 2;
    localparam int          BR_ZIP_W         = 33;
    localparam int          FLUSH_ZIP_W      = 33;

    // EMPTY: nothing pending; WAIT: address accepted, data pending;
    // HAVE: instruction parked in the holding buffer.
    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HAVE  = 2'd2
    } fs_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_entry_t;

endpackage

// File: rtl/if_sramlike_stage_if.sv
// Sram-like instruction port: request channel (req/addr_ok) and
// in-order response channel (data_ok/rdata).
interface if_sramlike_stage_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/if_sramlike_stage_fs_inst_buf.sv
// One-entry {pc, inst} holding register used when ID stalls on returned data.
module fs_inst_buf
    import if_sramlike_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clr,
    input  logic      ld,
    input  fs_entry_t din,
    output fs_entry_t dout
);

    fs_entry_t entry_q;

    // Hold the parked instruction; clear wins over load.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            entry_q <= '0;
        end else if (ld) begin
            entry_q <= din;
        end
    end

    assign dout = entry_q;

endmodule

// File: rtl/if_sramlike_stage.sv
// Pre-IF + IF stage: next-PC generation, fetch issue on the sram-like port,
// return buffering and redirect handling with discard of in-flight reads.
module if_sramlike_stage
    import if_sramlike_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DISC_W   = DISC_W_DEFAULT
)(
    input  logic                   clk,
    input  logic                   reset,
    if_sramlike_stage_if.master    inst_sram,
    input  logic                   ds_allowin,
    input  logic [BR_ZIP_W-1:0]    br_zip,
    input  logic [FLUSH_ZIP_W-1:0] flush_zip,
    output logic                   fs2ds_valid,
    output logic [31:0]            fs_inst,
    output logic [31:0]            fs_pc
);

    fs_state_e         fs_state;
    logic [31:0]       pf_pc;
    logic [31:0]       fs_pc_r;
    logic [DISC_W-1:0] disc_cnt;
    fs_entry_t         buf_q;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        in_wait;
    logic        in_have;
    logic        data_use;
    logic        data_drop;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        req;
    logic        accept;
    logic        disc_inc;
    logic        buf_ld;
    logic        buf_clr;

    assign redirect        = flush_zip[32] | br_zip[32];
    assign redirect_target = flush_zip[32] ? flush_zip[31:0] : br_zip[31:0];

    assign in_wait   = (fs_state == FS_WAIT);
    assign in_have   = (fs_state == FS_HAVE);
    // Responses owed to cancelled fetches come back first and are dropped.
    assign data_drop = inst_sram.data_ok & (disc_cnt != '0);
    assign data_use  = inst_sram.data_ok & (disc_cnt == '0) & in_wait;

    assign fs_ready_go = in_have | data_use;
    assign fs_allowin  = (fs_state == FS_EMPTY) | (fs_ready_go & ds_allowin);
    assign req         = ~reset & fs_allowin & ~redirect & (disc_cnt != '1);
    assign accept      = req & inst_sram.addr_ok;

    // A redirect while waiting orphans the pending read unless it returns now.
    assign disc_inc = redirect & in_wait & ~data_use;

    assign buf_ld  = data_use & ~ds_allowin & ~redirect;
    assign buf_clr = in_have & (redirect | ds_allowin);

    fs_inst_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .clr   (buf_clr),
        .ld    (buf_ld),
        .din   ('{pc: fs_pc_r, inst: inst_sram.rdata}),
        .dout  (buf_q)
    );

    // FS state, fetch PC and discard bookkeeping.
    // NOTE: all state here updates with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_state <= FS_EMPTY;
            pf_pc    <= RESET_PC;
            fs_pc_r  <= 32'd0;
            disc_cnt <= '0;
        end else begin
            if (disc_inc && !data_drop) begin
                disc_cnt <= disc_cnt + 1'b1;
            end else if (data_drop && !disc_inc) begin
                disc_cnt <= disc_cnt - 1'b1;
            end

            if (redirect) begin
                pf_pc    <= redirect_target;
                fs_state <= FS_EMPTY;
            end else if (accept) begin
                fs_pc_r  <= pf_pc;
                pf_pc    <= pf_pc + 32'd4;
                fs_state <= FS_WAIT;
            end else if (data_use) begin
                fs_state <= ds_allowin ? FS_EMPTY : FS_HAVE;
            end else if (in_have && ds_allowin) begin
                fs_state <= FS_EMPTY;
            end
        end
    end

    // NOTE: outputs are gated by reset so ID sees nothing during the reset cycle,
    // before the synchronous clear has taken effect.
    assign fs2ds_valid = ~reset & fs_ready_go & ~redirect;
    assign fs_inst     = reset ? 32'd0 : (in_have ? buf_q.inst : inst_sram.rdata);
    assign fs_pc       = reset ? 32'd0 : (in_have ? buf_q.pc   : fs_pc_r);

    assign inst_sram.req   = req;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = 2'b10;
    assign inst_sram.wstrb = 4'd0;
    assign inst_sram.addr  = pf_pc;
    assign inst_sram.wdata = 32'd0;

endmodule
